// File: rtl/cache_read_controller.sv
// Load-side lookup controller for the L0 data cache: issues the RAM read index in EX,
// resolves hit/miss in MA, and fetches missing or MMIO words over a valid/ready channel.
module cache_read_controller #(
    parameter int XLEN            = 32,
    parameter int CacheIndexWidth = 7,
    parameter int CacheTagWidth   = 7,
    parameter logic [XLEN-1:0] MMIO_ADDR = 32'h4000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_load_valid_ex,
    input  logic [XLEN-1:0]            i_load_address_ex,
    input  logic [XLEN/8-1:0]          i_load_byte_mask_ex,
    output logic [CacheIndexWidth-1:0] o_cache_read_index,
    input  logic [XLEN-1:0]            i_cache_read_data,
    input  logic [CacheTagWidth-1:0]   i_cache_read_tag,
    input  logic [XLEN/8-1:0]          i_cache_read_valid,
    input  logic                       i_cache_write_enable,
    input  logic [CacheIndexWidth-1:0] i_cache_write_index,
    input  logic [XLEN/8-1:0]          i_cache_write_byte_enable,
    input  logic [XLEN-1:0]            i_cache_write_data,
    input  logic [CacheTagWidth-1:0]   i_cache_write_tag,
    input  logic [XLEN/8-1:0]          i_cache_write_valid,
    output logic                       o_mem_req_valid,
    output logic [XLEN-1:0]            o_mem_req_address,
    input  logic                       i_mem_req_ready,
    input  logic                       i_mem_rsp_valid,
    input  logic [XLEN-1:0]            i_mem_rsp_data,
    output logic [XLEN-1:0]            o_load_data_ma,
    output logic                       o_load_data_valid_ma,
    output logic                       o_hit_ma,
    output logic                       o_stall_for_miss
);

    localparam int NB = XLEN / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                       r_abort;
    logic                       w_abort_next;
    logic [XLEN-1:0]            r_addr_ma;
    logic [NB-1:0]              r_mask_ma;
    logic [XLEN-1:0]            r_rsp_data;

    logic                       r_byp_hit;
    logic [CacheTagWidth-1:0]   r_byp_tag;
    logic [NB-1:0]              r_byp_valid;
    logic [NB-1:0]              r_byp_be;
    logic [XLEN-1:0]            r_byp_data;

    logic                       w_accept;
    logic                       w_stall;
    logic                       w_hit;
    logic                       w_is_mmio;
    logic [CacheIndexWidth-1:0] w_ex_index;
    logic [CacheIndexWidth-1:0] w_ma_index;
    logic [CacheTagWidth-1:0]   w_ma_tag;
    logic [CacheTagWidth-1:0]   w_eff_tag;
    logic [NB-1:0]              w_eff_valid;
    logic [XLEN-1:0]            w_eff_data;

    assign w_ex_index = i_load_address_ex[2 +: CacheIndexWidth];
    assign w_ma_index = r_addr_ma[2 +: CacheIndexWidth];
    assign w_ma_tag   = r_addr_ma[(2 + CacheIndexWidth) +: CacheTagWidth];
    assign w_is_mmio  = (r_addr_ma >= MMIO_ADDR);

    // A held LOOKUP keeps re-reading its own line so data tracks later writes.
    assign o_cache_read_index = (r_state == S_LOOKUP && i_stall) ? w_ma_index : w_ex_index;

    // The RAM returns pre-write contents when read and written in the same cycle,
    // so a same-index write from the previous cycle overrides the RAM outputs.
    always_comb begin
        w_eff_tag   = i_cache_read_tag;
        w_eff_valid = i_cache_read_valid;
        w_eff_data  = i_cache_read_data;
        if (r_byp_hit) begin
            w_eff_tag   = r_byp_tag;
            w_eff_valid = r_byp_valid;
            for (int b = 0; b < NB; b++) begin
                if (r_byp_be[b]) begin
                    w_eff_data[8*b +: 8] = r_byp_data[8*b +: 8];
                end
            end
        end
    end

    assign w_hit = (w_eff_tag == w_ma_tag) && ((w_eff_valid & r_mask_ma) == r_mask_ma) && !w_is_mmio;

    assign w_stall = ((r_state == S_LOOKUP) && !i_flush && !w_hit) ||
                     (r_state == S_MISS_REQ) || (r_state == S_MISS_WAIT);
    assign o_stall_for_miss = w_stall;

    assign w_accept = i_load_valid_ex && !i_stall && !w_stall && !i_flush;

    always_comb begin
        w_state_next         = r_state;
        w_abort_next         = r_abort;
        o_mem_req_valid      = 1'b0;
        o_mem_req_address    = '0;
        o_load_data_ma       = '0;
        o_load_data_valid_ma = 1'b0;
        o_hit_ma             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (i_flush) begin
                    w_state_next = S_IDLE;
                end else if (w_hit) begin
                    o_load_data_valid_ma = 1'b1;
                    o_hit_ma             = 1'b1;
                    o_load_data_ma       = w_eff_data;
                    w_state_next         = (i_stall || w_accept) ? S_LOOKUP : S_IDLE;
                end else begin
                    w_state_next = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                o_mem_req_valid   = 1'b1;
                o_mem_req_address = w_is_mmio ? r_addr_ma : {r_addr_ma[XLEN-1:2], 2'b00};
                if (i_flush) w_abort_next = 1'b1;
                if (i_mem_req_ready) w_state_next = S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
                if (i_flush) w_abort_next = 1'b1;
                if (i_mem_rsp_valid) begin
                    w_state_next = (r_abort || i_flush) ? S_IDLE : S_RESP;
                    w_abort_next = 1'b0;
                end
            end
            S_RESP: begin
                o_load_data_valid_ma = 1'b1;
                o_load_data_ma       = r_rsp_data;
                w_state_next         = w_accept ? S_LOOKUP : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_abort   <= 1'b0;
            r_byp_hit <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_abort   <= w_abort_next;
            r_byp_hit <= i_cache_write_enable && (i_cache_write_index == o_cache_read_index);
        end
    end

    // Datapath registers carry no reset; every consumer is qualified by state.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr_ma <= i_load_address_ex;
            r_mask_ma <= i_load_byte_mask_ex;
        end
        if (r_state == S_MISS_WAIT && i_mem_rsp_valid) begin
            r_rsp_data <= i_mem_rsp_data;
        end
        r_byp_tag   <= i_cache_write_tag;
        r_byp_valid <= i_cache_write_valid;
        r_byp_be    <= i_cache_write_byte_enable;
        r_byp_data  <= i_cache_write_data;
    end

endmodule

// File: tb/tb_cache_read_controller.sv
// Directed bench for cache_read_controller: a synchronous cache RAM model plus
// hand-driven memory channel, with hand-computed expectations per cycle.
module tb_cache_read_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in, flush;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_mask;
    logic [6:0]  rd_idx;
    logic [31:0] rd_data;
    logic [6:0]  rd_tag;
    logic [3:0]  rd_valid;
    logic        wr_en;
    logic [6:0]  wr_idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [6:0]  wr_tag;
    logic [3:0]  wr_valid;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] load_data;
    logic        load_valid;
    logic        hit;
    logic        miss_stall;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram_data  [0:127];
    logic [6:0]  ram_tag   [0:127];
    logic [3:0]  ram_valid [0:127];

    always #5 clk = ~clk;

    cache_read_controller dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_stall                   (stall_in),
        .i_flush                   (flush),
        .i_load_valid_ex           (ld_valid),
        .i_load_address_ex         (ld_addr),
        .i_load_byte_mask_ex       (ld_mask),
        .o_cache_read_index        (rd_idx),
        .i_cache_read_data         (rd_data),
        .i_cache_read_tag          (rd_tag),
        .i_cache_read_valid        (rd_valid),
        .i_cache_write_enable      (wr_en),
        .i_cache_write_index       (wr_idx),
        .i_cache_write_byte_enable (wr_be),
        .i_cache_write_data        (wr_data),
        .i_cache_write_tag         (wr_tag),
        .i_cache_write_valid       (wr_valid),
        .o_mem_req_valid           (req_valid),
        .o_mem_req_address         (req_addr),
        .i_mem_req_ready           (req_ready),
        .i_mem_rsp_valid           (rsp_valid),
        .i_mem_rsp_data            (rsp_data),
        .o_load_data_ma            (load_data),
        .o_load_data_valid_ma      (load_valid),
        .o_hit_ma                  (hit),
        .o_stall_for_miss          (miss_stall)
    );

    // Synchronous RAM: read returns the pre-write contents on a same-edge write.
    always @(posedge clk) begin
        rd_data  <= ram_data[rd_idx];
        rd_tag   <= ram_tag[rd_idx];
        rd_valid <= ram_valid[rd_idx];
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) ram_data[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
            ram_tag[wr_idx]   <= wr_tag;
            ram_valid[wr_idx] <= wr_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [6:0] idx, input logic [3:0] be, input logic [31:0] d,
                          input logic [6:0] t, input logic [3:0] v);
        wr_en = 1'b1; wr_idx = idx; wr_be = be; wr_data = d; wr_tag = t; wr_valid = v;
    endtask

    task automatic clr_wr();
        wr_en = 1'b0; wr_idx = '0; wr_be = '0; wr_data = '0; wr_tag = '0; wr_valid = '0;
    endtask

    task automatic wr_pulse(input logic [6:0] idx, input logic [3:0] be, input logic [31:0] d,
                            input logic [6:0] t, input logic [3:0] v);
        set_wr(idx, be, d, t, v);
        cyc();
        clr_wr();
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] m);
        ld_valid = 1'b1; ld_addr = a; ld_mask = m;
    endtask

    task automatic ld_clr();
        ld_valid = 1'b0; ld_addr = '0; ld_mask = '0;
    endtask

    // Entered at the start of a MISS_REQ cycle; accepts at once, responds next cycle.
    task automatic serve_miss(input string tag, input logic [31:0] exp_addr, input logic [31:0] d);
        req_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_req_valid"}, req_valid, 1);
        chk({tag, "_req_addr"}, req_addr, exp_addr);
        cyc();
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = d;
        @(negedge clk);
        chk({tag, "_wait_stall"}, miss_stall, 1);
        cyc();
        rsp_valid = 1'b0; rsp_data = '0;
        @(negedge clk);
        chk({tag, "_resp_data"}, load_data, d);
        chk({tag, "_resp_valid"}, load_valid, 1);
        chk({tag, "_resp_stall"}, miss_stall, 0);
        chk({tag, "_resp_hit"}, hit, 0);
        cyc();
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        ld_clr();
        clr_wr();
        cyc(); cyc();
        @(negedge clk);
        chk("rst_stall", miss_stall, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_data_valid", load_valid, 0);
        chk("rst_hit", hit, 0);
        chk("rst_index", rd_idx, 0);
        cyc();
        rst = 1'b0;

        // Hit: 0x1814 -> index 5, tag 12
        wr_pulse(7'd5, 4'hF, 32'hDEADBEEF, 7'd12, 4'hF);
        ld(32'h0000_1814, 4'hF);
        @(negedge clk);
        chk("hit_index", rd_idx, 5);
        cyc();
        ld_clr();
        @(negedge clk);
        chk("hit_data", load_data, 32'hDEADBEEF);
        chk("hit_valid", load_valid, 1);
        chk("hit_hit", hit, 1);
        chk("hit_stall", miss_stall, 0);
        cyc();
        @(negedge clk);
        chk("hit_after_valid", load_valid, 0);

        // Miss: 0x3816 -> index 5, tag 28; request is word-aligned
        ld(32'h0000_3816, 4'hC);
        cyc();
        ld_clr();
        @(negedge clk);
        chk("miss_lookup_stall", miss_stall, 1);
        chk("miss_lookup_valid", load_valid, 0);
        chk("miss_lookup_hit", hit, 0);
        chk("miss_lookup_req", req_valid, 0);
        cyc();
        @(negedge clk);
        chk("miss_req1_valid", req_valid, 1);
        chk("miss_req1_addr", req_addr, 32'h0000_3814);
        chk("miss_req1_stall", miss_stall, 1);
        cyc();
        @(negedge clk);
        chk("miss_req2_valid", req_valid, 1);
        cyc();
        req_ready = 1'b1;
        @(negedge clk);
        chk("miss_req3_valid", req_valid, 1);
        cyc();
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
        @(negedge clk);
        chk("miss_wait_req", req_valid, 0);
        chk("miss_wait_stall", miss_stall, 1);
        cyc();
        rsp_valid = 1'b0; rsp_data = '0;
        @(negedge clk);
        chk("miss_resp_data", load_data, 32'h1234_5678);
        chk("miss_resp_valid", load_valid, 1);
        chk("miss_resp_stall", miss_stall, 0);
        cyc();
        @(negedge clk);
        chk("miss_idle_valid", load_valid, 0);

        // Same-cycle write to the line being read merges bytes 1:0
        wr_pulse(7'd5, 4'hF, 32'h1111_2222, 7'd12, 4'hF);
        set_wr(7'd5, 4'b0011, 32'h0000_ABCD, 7'd12, 4'hF);
        ld(32'h0000_1814, 4'h3);
        cyc();
        clr_wr();
        ld_clr();
        @(negedge clk);
        chk("byp_data", load_data, 32'h1111_ABCD);
        chk("byp_hit", hit, 1);
        cyc();

        // Held hit re-reads its own line and picks up a write made while held
        ld(32'h0000_1814, 4'hF);
        cyc();
        ld_clr();
        ld_addr = 32'h0000_0100;
        stall_in = 1'b1;
        set_wr(7'd5, 4'hF, 32'hCAFE_F00D, 7'd12, 4'hF);
        @(negedge clk);
        chk("hold1_index", rd_idx, 5);
        chk("hold1_valid", load_valid, 1);
        chk("hold1_data", load_data, 32'h1111_ABCD);
        cyc();
        clr_wr();
        @(negedge clk);
        chk("hold2_valid", load_valid, 1);
        chk("hold2_data", load_data, 32'hCAFE_F00D);
        cyc();
        stall_in = 1'b0;
        ld_addr = '0;
        @(negedge clk);
        chk("hold3_data", load_data, 32'hCAFE_F00D);
        chk("hold3_valid", load_valid, 1);
        cyc();

        // Flush in LOOKUP drops the hit
        ld(32'h0000_1814, 4'hF);
        cyc();
        ld_clr();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_lk_valid", load_valid, 0);
        chk("flush_lk_hit", hit, 0);
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_lk_idle_valid", load_valid, 0);
        cyc();

        // Partial valid: 0x1824 -> index 9, tag 12; bytes 3:2 invalid
        wr_pulse(7'd9, 4'hF, 32'hA5A5_A5A5, 7'd12, 4'b0011);
        ld(32'h0000_1824, 4'hC);
        cyc();
        ld_clr();
        @(negedge clk);
        chk("part_stall", miss_stall, 1);
        chk("part_hit", hit, 0);
        cyc();
        serve_miss("part", 32'h0000_1824, 32'h0BAD_F00D);

        // MMIO: line 0 tag 0 is fully valid, yet the load must go to memory
        wr_pulse(7'd0, 4'hF, 32'h5555_5555, 7'd0, 4'hF);
        ld(32'h4000_0000, 4'hF);
        cyc();
        ld_clr();
        @(negedge clk);
        chk("mmio_stall", miss_stall, 1);
        chk("mmio_hit", hit, 0);
        chk("mmio_valid", load_valid, 0);
        cyc();
        serve_miss("mmio", 32'h4000_0000, 32'h7777_8888);

        // Flush in MISS_WAIT: stall until response, then idle without data
        ld(32'h0000_3814, 4'hF);
        cyc();
        ld_clr();
        cyc();
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("fw_stall1", miss_stall, 1);
        cyc();
        flush = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'h9999_0000;
        @(negedge clk);
        chk("fw_stall2", miss_stall, 1);
        chk("fw_valid2", load_valid, 0);
        cyc();
        rsp_valid = 1'b0; rsp_data = '0;
        @(negedge clk);
        chk("fw_after_valid", load_valid, 0);
        chk("fw_after_stall", miss_stall, 0);
        chk("fw_after_req", req_valid, 0);
        cyc();

        // Reset while in MISS_REQ
        ld(32'h0000_3814, 4'hF);
        cyc();
        ld_clr();
        cyc();
        @(negedge clk);
        chk("rmid_req_before", req_valid, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_stall", miss_stall, 0);
        chk("rmid_req_valid", req_valid, 0);
        chk("rmid_req_addr", req_addr, 0);
        chk("rmid_data_valid", load_valid, 0);
        chk("rmid_data", load_data, 0);
        chk("rmid_hit", hit, 0);
        chk("rmid_index", rd_idx, 0);
        rsp_valid = 1'b1; rsp_data = 32'hFFFF_FFFF;
        cyc();
        rsp_valid = 1'b0; rsp_data = '0;
        @(negedge clk);
        chk("idle_rsp_ignored", load_valid, 0);

        // Controller is usable again after the reset
        ld(32'h0000_1814, 4'hF);
        cyc();
        ld_clr();
        @(negedge clk);
        chk("post_rst_data", load_data, 32'hCAFE_F00D);
        chk("post_rst_hit", hit, 1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
